// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the single-bus CPU control unit:
//                opcodes, sequencer state encoding, instruction classes,
//                the control-strobe bundle and the last-step lookup.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    // Opcodes as found in IR[31:27]
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Sequencer step states; T0..T7 are consecutive so a step advance is +1
    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_T6    = 4'd7,
        ST_T7    = 4'd8,
        ST_HALT  = 4'd9
    } state_t;

    // Instruction classes sharing one execute sequence
    typedef enum logic [3:0] {
        CLS_RTYPE  = 4'd0,
        CLS_UNARY  = 4'd1,
        CLS_IMM    = 4'd2,
        CLS_LDI    = 4'd3,
        CLS_LD     = 4'd4,
        CLS_ST     = 4'd5,
        CLS_BR     = 4'd6,
        CLS_JR     = 4'd7,
        CLS_JAL    = 4'd8,
        CLS_MFHI   = 4'd9,
        CLS_MFLO   = 4'd10,
        CLS_IN     = 4'd11,
        CLS_OUT    = 4'd12,
        CLS_MULDIV = 4'd13,
        CLS_NOP    = 4'd14,
        CLS_HALT   = 4'd15
    } op_class_t;

    // Datapath strobe bundle produced by the output decoder
    typedef struct packed {
        logic gra;
        logic grb;
        logic grc;
        logic rin;
        logic rout;
        logic ba_out;
        logic c_out;
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic ir_in;
        logic mar_in;
        logic mdr_in;
        logic mdr_out;
        logic y_in;
        logic z_in;
        logic zhigh_out;
        logic zlow_out;
        logic hi_in;
        logic hi_out;
        logic lo_in;
        logic lo_out;
        logic inport_out;
        logic outport_in;
        logic con_in;
        logic read;
        logic ram_write;
    } ctrl_t;

    // Final execute step of each class; the FSM leaves for T0/HALT from here
    function automatic state_t last_step(input op_class_t cls);
        state_t s;
        case (cls)
            CLS_RTYPE, CLS_UNARY, CLS_IMM, CLS_LDI: s = ST_T5;
            CLS_LD, CLS_ST:                          s = ST_T7;
            CLS_BR, CLS_MULDIV:                      s = ST_T6;
            CLS_JAL:                                 s = ST_T4;
            CLS_JR, CLS_MFHI, CLS_MFLO,
            CLS_IN, CLS_OUT:                         s = ST_T3;
            default:                                 s = ST_T2;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_if
//  Description : Bundle between the control unit and the datapath: IR, CON
//                and stop inward, every control strobe, alu_op and run out.
//  Revision    : 1.0  initial release
// ============================================================================
interface control_unit_if;

    logic [31:0] IR;
    logic        CON;
    logic        stop;
    logic        run;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    logic        PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout;
    logic        Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout;
    logic        InPortout, Out_portIn, CONin;
    logic        read, RAMwrite;
    logic [4:0]  alu_op;

    // Control unit side
    modport master (
        input  IR, CON, stop,
        output run,
        output Gra, Grb, Grc, Rin, Rout, BAout, Cout,
        output PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout,
        output Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout,
        output InPortout, Out_portIn, CONin,
        output read, RAMwrite,
        output alu_op
    );

    // Datapath side
    modport slave (
        output IR, CON, stop,
        input  run,
        input  Gra, Grb, Grc, Rin, Rout, BAout, Cout,
        input  PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout,
        input  Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout,
        input  InPortout, Out_portIn, CONin,
        input  read, RAMwrite,
        input  alu_op
    );

endinterface
`default_nettype wire

// File: rtl/control_unit_op_class_decode.sv
`default_nettype none
// ============================================================================
//  Module      : op_class_decode
//  Description : Combinational opcode -> instruction class and ALU opcode.
//                Config macro CU_MULDIV_EN: when defined, mul/div get their
//                own class; otherwise both decode as nop.
//  Revision    : 1.0  initial release
// ============================================================================
module op_class_decode
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class,
    output logic [4:0] alu_op
);

    // Address-forming instructions reuse the adder; immediates map to their ALU op
    always_comb begin
        op_class = CLS_NOP;
        alu_op   = 5'b00000;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
                op_class = CLS_RTYPE;
                alu_op   = opcode;
            end
            OP_NEG, OP_NOT: begin
                op_class = CLS_UNARY;
                alu_op   = opcode;
            end
            OP_ADDI: begin
                op_class = CLS_IMM;
                alu_op   = OP_ADD;
            end
            OP_ANDI: begin
                op_class = CLS_IMM;
                alu_op   = OP_AND;
            end
            OP_ORI: begin
                op_class = CLS_IMM;
                alu_op   = OP_OR;
            end
            OP_LDI: begin
                op_class = CLS_LDI;
                alu_op   = OP_ADD;
            end
            OP_LD: begin
                op_class = CLS_LD;
                alu_op   = OP_ADD;
            end
            OP_ST: begin
                op_class = CLS_ST;
                alu_op   = OP_ADD;
            end
            OP_BR: begin
                op_class = CLS_BR;
                alu_op   = OP_ADD;
            end
            OP_JR:   op_class = CLS_JR;
            OP_JAL:  op_class = CLS_JAL;
            OP_MFHI: op_class = CLS_MFHI;
            OP_MFLO: op_class = CLS_MFLO;
            OP_IN:   op_class = CLS_IN;
            OP_OUT:  op_class = CLS_OUT;
`ifdef CU_MULDIV_EN
            OP_MUL, OP_DIV: begin
                op_class = CLS_MULDIV;
                alu_op   = opcode;
            end
`endif
            OP_HALT: op_class = CLS_HALT;
            default: op_class = CLS_NOP;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Moore sequencer for the single-bus CPU. Fetch in T0-T2,
//                per-class execute in T3-T7, HALT until clear. Outputs decode
//                from the registered state, IR and a registered copy of CON.
//                Config macro CU_MULDIV_EN enables the mul/div sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module control_unit
    import cpu_pkg::*;
#(
    parameter int RESET_PC_STEPS = 1
) (
    input  logic           clock,
    input  logic           clear,
    control_unit_if.master bus
);

    localparam int c_cnt_w = (RESET_PC_STEPS > 1) ? $clog2(RESET_PC_STEPS) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last =
        (RESET_PC_STEPS > 1) ? c_cnt_w'(RESET_PC_STEPS - 1) : '0;

    state_t             r_state;
    state_t             w_next_state;
    state_t             w_last;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_con;
    op_class_t          w_cls;
    logic [4:0]         w_dec_alu;
    ctrl_t              w_ctrl;
    logic               w_run;
    logic               w_unused_ir;

    op_class_decode u_decode (
        .opcode   (bus.IR[31:27]),
        .op_class (w_cls),
        .alu_op   (w_dec_alu)
    );

    assign w_last      = last_step(w_cls);
    assign w_unused_ir = ^bus.IR[26:0];

    // State register; clear aborts any instruction at once
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Idle-cycle counter for the RESET state, plus CON sampled so the branch
    // decision comes from a flop rather than a live input
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_cnt <= '0;
            r_con <= 1'b0;
        end else begin
            r_con <= bus.CON;
            if (r_state == ST_RESET && r_cnt != c_cnt_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Next-state: fetch, then step through the class sequence; stop and
    // halt are honoured only at the instruction's final step
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RESET: begin
                if (r_cnt == c_cnt_last) begin
                    w_next_state = ST_T0;
                end
            end
            ST_T0: w_next_state = ST_T1;
            ST_T1: w_next_state = ST_T2;
            ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                if (r_state == w_last || r_state == ST_T7) begin
                    w_next_state = (w_cls == CLS_HALT || bus.stop) ? ST_HALT : ST_T0;
                end else begin
                    w_next_state = state_t'(r_state + 4'd1);
                end
            end
            ST_HALT: w_next_state = ST_HALT;
            default: w_next_state = ST_RESET;
        endcase
    end

    // Output decode: one-cycle strobes per step and instruction class
    always_comb begin
        w_ctrl = '0;
        w_run  = 1'b0;
        case (r_state)
            ST_T0: begin
                w_run         = 1'b1;
                w_ctrl.pc_out = 1'b1;
                w_ctrl.mar_in = 1'b1;
                w_ctrl.inc_pc = 1'b1;
            end
            ST_T1: begin
                w_run         = 1'b1;
                w_ctrl.read   = 1'b1;
                w_ctrl.mdr_in = 1'b1;
            end
            ST_T2: begin
                w_run          = 1'b1;
                w_ctrl.mdr_out = 1'b1;
                w_ctrl.ir_in   = 1'b1;
            end
            ST_T3: begin
                w_run = 1'b1;
                case (w_cls)
                    CLS_RTYPE, CLS_UNARY, CLS_IMM: begin
                        w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.y_in = 1'b1;
                    end
                    CLS_LDI, CLS_LD, CLS_ST: begin
                        w_ctrl.grb = 1'b1; w_ctrl.ba_out = 1'b1; w_ctrl.y_in = 1'b1;
                    end
                    CLS_BR: begin
                        w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.con_in = 1'b1;
                    end
                    CLS_JR: begin
                        w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.pc_in = 1'b1;
                    end
                    CLS_JAL: begin
                        w_ctrl.pc_out = 1'b1; w_ctrl.grb = 1'b1; w_ctrl.rin = 1'b1;
                    end
                    CLS_MFHI: begin
                        w_ctrl.hi_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1;
                    end
                    CLS_MFLO: begin
                        w_ctrl.lo_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1;
                    end
                    CLS_IN: begin
                        w_ctrl.inport_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1;
                    end
                    CLS_OUT: begin
                        w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.outport_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.y_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                w_run = 1'b1;
                case (w_cls)
                    CLS_RTYPE: begin
                        w_ctrl.grc = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.z_in = 1'b1;
                    end
                    CLS_UNARY, CLS_MULDIV: begin
                        w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.z_in = 1'b1;
                    end
                    CLS_IMM, CLS_LDI, CLS_LD, CLS_ST: begin
                        w_ctrl.c_out = 1'b1; w_ctrl.z_in = 1'b1;
                    end
                    CLS_BR: begin
                        w_ctrl.pc_out = 1'b1; w_ctrl.y_in = 1'b1;
                    end
                    CLS_JAL: begin
                        w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.pc_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                w_run = 1'b1;
                case (w_cls)
                    CLS_RTYPE, CLS_UNARY, CLS_IMM, CLS_LDI: begin
                        w_ctrl.zlow_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        w_ctrl.zlow_out = 1'b1; w_ctrl.mar_in = 1'b1;
                    end
                    CLS_BR: begin
                        w_ctrl.c_out = 1'b1; w_ctrl.z_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        w_ctrl.zlow_out = 1'b1; w_ctrl.lo_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                w_run = 1'b1;
                case (w_cls)
                    CLS_LD: begin
                        w_ctrl.read = 1'b1; w_ctrl.mdr_in = 1'b1;
                    end
                    CLS_ST: begin
                        w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.mdr_in = 1'b1;
                    end
                    CLS_BR: begin
                        w_ctrl.zlow_out = r_con; w_ctrl.pc_in = r_con;
                    end
                    CLS_MULDIV: begin
                        w_ctrl.zhigh_out = 1'b1; w_ctrl.hi_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                w_run = 1'b1;
                case (w_cls)
                    CLS_LD: begin
                        w_ctrl.mdr_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1;
                    end
                    CLS_ST: w_ctrl.ram_write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // The ALU opcode is presented only while Z captures the result
    assign bus.alu_op     = w_ctrl.z_in ? w_dec_alu : 5'b00000;
    assign bus.run        = w_run;
    assign bus.Gra        = w_ctrl.gra;
    assign bus.Grb        = w_ctrl.grb;
    assign bus.Grc        = w_ctrl.grc;
    assign bus.Rin        = w_ctrl.rin;
    assign bus.Rout       = w_ctrl.rout;
    assign bus.BAout      = w_ctrl.ba_out;
    assign bus.Cout       = w_ctrl.c_out;
    assign bus.PCout      = w_ctrl.pc_out;
    assign bus.PCin       = w_ctrl.pc_in;
    assign bus.IncPC      = w_ctrl.inc_pc;
    assign bus.IRin       = w_ctrl.ir_in;
    assign bus.MARin      = w_ctrl.mar_in;
    assign bus.MDRin      = w_ctrl.mdr_in;
    assign bus.MDRout     = w_ctrl.mdr_out;
    assign bus.Yin        = w_ctrl.y_in;
    assign bus.Zin        = w_ctrl.z_in;
    assign bus.Zhighout   = w_ctrl.zhigh_out;
    assign bus.Zlowout    = w_ctrl.zlow_out;
    assign bus.HIin       = w_ctrl.hi_in;
    assign bus.HIout      = w_ctrl.hi_out;
    assign bus.LOin       = w_ctrl.lo_in;
    assign bus.LOout      = w_ctrl.lo_out;
    assign bus.InPortout  = w_ctrl.inport_out;
    assign bus.Out_portIn = w_ctrl.outport_in;
    assign bus.CONin      = w_ctrl.con_in;
    assign bus.read       = w_ctrl.read;
    assign bus.RAMwrite   = w_ctrl.ram_write;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit
//  Description : Self-checking bench for control_unit. Each instruction's
//                expected per-cycle strobe vectors are queued when it is
//                issued and compared cycle by cycle on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_control_unit;

    localparam int RESET_STEPS = 1;

    // Expected-vector bit positions: {alu_op[4:0], run, 27 strobes}
    localparam logic [32:0] GRA   = 33'h1 << 0;
    localparam logic [32:0] GRB   = 33'h1 << 1;
    localparam logic [32:0] GRC   = 33'h1 << 2;
    localparam logic [32:0] RIN   = 33'h1 << 3;
    localparam logic [32:0] ROUT  = 33'h1 << 4;
    localparam logic [32:0] BAOUT = 33'h1 << 5;
    localparam logic [32:0] COUT  = 33'h1 << 6;
    localparam logic [32:0] PCOUT = 33'h1 << 7;
    localparam logic [32:0] PCIN  = 33'h1 << 8;
    localparam logic [32:0] INCPC = 33'h1 << 9;
    localparam logic [32:0] IRIN  = 33'h1 << 10;
    localparam logic [32:0] MARIN = 33'h1 << 11;
    localparam logic [32:0] MDRIN = 33'h1 << 12;
    localparam logic [32:0] MDROU = 33'h1 << 13;
    localparam logic [32:0] YIN   = 33'h1 << 14;
    localparam logic [32:0] ZIN   = 33'h1 << 15;
    localparam logic [32:0] ZHI   = 33'h1 << 16;
    localparam logic [32:0] ZLO   = 33'h1 << 17;
    localparam logic [32:0] HIIN  = 33'h1 << 18;
    localparam logic [32:0] HIOUT = 33'h1 << 19;
    localparam logic [32:0] LOIN  = 33'h1 << 20;
    localparam logic [32:0] LOOUT = 33'h1 << 21;
    localparam logic [32:0] INPO  = 33'h1 << 22;
    localparam logic [32:0] OUTPI = 33'h1 << 23;
    localparam logic [32:0] CONIN = 33'h1 << 24;
    localparam logic [32:0] READ  = 33'h1 << 25;
    localparam logic [32:0] RAMWR = 33'h1 << 26;
    localparam logic [32:0] RUN   = 33'h1 << 27;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic [32:0] obs;
    logic [32:0] exp_v;
    logic [32:0] sb_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    control_unit_if bus ();

    control_unit #(.RESET_PC_STEPS(RESET_STEPS)) dut (
        .clock (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign obs = {bus.alu_op, bus.run, bus.RAMwrite, bus.read, bus.CONin, bus.Out_portIn,
                  bus.InPortout, bus.LOout, bus.LOin, bus.HIout, bus.HIin, bus.Zlowout,
                  bus.Zhighout, bus.Zin, bus.Yin, bus.MDRout, bus.MDRin, bus.MARin, bus.IRin,
                  bus.IncPC, bus.PCin, bus.PCout, bus.Cout, bus.BAout, bus.Rout, bus.Rin,
                  bus.Grc, bus.Grb, bus.Gra};

    function automatic logic [32:0] al(input logic [4:0] op);
        return {op, 28'h0};
    endfunction

    // Reference model: queue the expected vector of every cycle of one instruction
    task automatic push_instr(input logic [31:0] ir, input logic con);
        logic [4:0] op;
        op = ir[31:27];
        sb_q.push_back(RUN | PCOUT | MARIN | INCPC);
        sb_q.push_back(RUN | READ | MDRIN);
        sb_q.push_back(RUN | MDROU | IRIN);
        case (op) inside
            [5'd3:5'd11]: begin // add .. shl
                sb_q.push_back(RUN | GRB | ROUT | YIN);
                sb_q.push_back(RUN | GRC | ROUT | ZIN | al(op));
                sb_q.push_back(RUN | ZLO | GRA | RIN);
            end
            5'd17, 5'd18: begin // neg, not
                sb_q.push_back(RUN | GRB | ROUT | YIN);
                sb_q.push_back(RUN | GRB | ROUT | ZIN | al(op));
                sb_q.push_back(RUN | ZLO | GRA | RIN);
            end
            5'd12, 5'd13, 5'd14: begin // addi, andi, ori
                sb_q.push_back(RUN | GRB | ROUT | YIN);
                sb_q.push_back(RUN | COUT | ZIN |
                               al(op == 5'd12 ? 5'd3 : (op == 5'd13 ? 5'd5 : 5'd6)));
                sb_q.push_back(RUN | ZLO | GRA | RIN);
            end
            5'd1: begin // ldi
                sb_q.push_back(RUN | GRB | BAOUT | YIN);
                sb_q.push_back(RUN | COUT | ZIN | al(5'd3));
                sb_q.push_back(RUN | ZLO | GRA | RIN);
            end
            5'd0, 5'd2: begin // ld, st
                sb_q.push_back(RUN | GRB | BAOUT | YIN);
                sb_q.push_back(RUN | COUT | ZIN | al(5'd3));
                sb_q.push_back(RUN | ZLO | MARIN);
                if (op == 5'd0) begin
                    sb_q.push_back(RUN | READ | MDRIN);
                    sb_q.push_back(RUN | MDROU | GRA | RIN);
                end else begin
                    sb_q.push_back(RUN | GRA | ROUT | MDRIN);
                    sb_q.push_back(RUN | RAMWR);
                end
            end
            5'd19: begin // br
                sb_q.push_back(RUN | GRA | ROUT | CONIN);
                sb_q.push_back(RUN | PCOUT | YIN);
                sb_q.push_back(RUN | COUT | ZIN | al(5'd3));
                sb_q.push_back(con ? (RUN | ZLO | PCIN) : RUN);
            end
            5'd20: sb_q.push_back(RUN | GRA | ROUT | PCIN);
            5'd21: begin // jal
                sb_q.push_back(RUN | PCOUT | GRB | RIN);
                sb_q.push_back(RUN | GRA | ROUT | PCIN);
            end
            5'd22: sb_q.push_back(RUN | INPO | GRA | RIN);
            5'd23: sb_q.push_back(RUN | GRA | ROUT | OUTPI);
            5'd24: sb_q.push_back(RUN | HIOUT | GRA | RIN);
            5'd25: sb_q.push_back(RUN | LOOUT | GRA | RIN);
`ifdef CU_MULDIV_EN
            5'd15, 5'd16: begin // div, mul
                sb_q.push_back(RUN | GRA | ROUT | YIN);
                sb_q.push_back(RUN | GRB | ROUT | ZIN | al(op));
                sb_q.push_back(RUN | ZLO | LOIN);
                sb_q.push_back(RUN | ZHI | HIIN);
            end
`endif
            default: ; // nop, halt, unlisted: fetch only
        endcase
    endtask

    task automatic test_reset();
        bus.IR = 32'hD000_0000; bus.CON = 1'b0; bus.stop = 1'b0;
        clear = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs !== 33'h0) $display("FAIL reset_hold: got %h expected %h", obs, 33'h0);
        else n_pass++;
        @(posedge clk); #1 clear = 1'b0;
        for (int k = 0; k < RESET_STEPS; k++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== 33'h0) $display("FAIL reset_idle %0d: got %h expected %h", k, obs, 33'h0);
            else n_pass++;
        end
    endtask

    task automatic test_alu();
        logic [31:0] irs [7] = '{32'h18A2_0000, 32'h2000_0000, 32'h8880_0000, 32'h6880_0005,
                                 32'h7080_0007, 32'h6080_0001, 32'h0880_0042};
        for (int i = 0; i < 7; i++) begin
            push_instr(irs[i], 1'b0);
            for (int s = 0; sb_q.size() > 0; s++) begin
                @(negedge clk);
                exp_v = sb_q.pop_front();
                n_checks++;
                if (obs !== exp_v) $display("FAIL alu ir=%h step %0d: got %h expected %h", irs[i], s, obs, exp_v);
                else n_pass++;
                if (s == 0) bus.IR = irs[i];
            end
        end
    endtask

    task automatic test_mem();
        logic [31:0] irs [2] = '{32'h0080_0065, 32'h1080_0065};
        for (int i = 0; i < 2; i++) begin
            push_instr(irs[i], 1'b0);
            for (int s = 0; sb_q.size() > 0; s++) begin
                @(negedge clk);
                exp_v = sb_q.pop_front();
                n_checks++;
                if (obs !== exp_v) $display("FAIL mem ir=%h step %0d: got %h expected %h", irs[i], s, obs, exp_v);
                else n_pass++;
                if (s == 0) bus.IR = irs[i];
            end
        end
    endtask

    task automatic test_br();
        for (int i = 0; i < 2; i++) begin
            push_instr(32'h9880_0010, (i == 0));
            for (int s = 0; sb_q.size() > 0; s++) begin
                @(negedge clk);
                exp_v = sb_q.pop_front();
                n_checks++;
                if (obs !== exp_v) $display("FAIL br con=%0d step %0d: got %h expected %h", (i == 0), s, obs, exp_v);
                else n_pass++;
                if (s == 0) begin bus.IR = 32'h9880_0010; bus.CON = (i == 0); end
            end
        end
        bus.CON = 1'b0;
    endtask

    task automatic test_mul();
        logic [31:0] irs [2] = '{32'h8110_0000, 32'h7910_0000};
        for (int i = 0; i < 2; i++) begin
            push_instr(irs[i], 1'b0);
            for (int s = 0; sb_q.size() > 0; s++) begin
                @(negedge clk);
                exp_v = sb_q.pop_front();
                n_checks++;
                if (obs !== exp_v) $display("FAIL muldiv ir=%h step %0d: got %h expected %h", irs[i], s, obs, exp_v);
                else n_pass++;
                if (s == 0) bus.IR = irs[i];
            end
        end
    endtask

    task automatic test_misc();
        logic [31:0] irs [8] = '{32'hA080_0000, 32'hA8A0_0000, 32'hD000_0000, 32'hF800_0000,
                                 32'hC080_0000, 32'hC880_0000, 32'hB080_0000, 32'hB880_0000};
        for (int i = 0; i < 8; i++) begin
            push_instr(irs[i], 1'b0);
            for (int s = 0; sb_q.size() > 0; s++) begin
                @(negedge clk);
                exp_v = sb_q.pop_front();
                n_checks++;
                if (obs !== exp_v) $display("FAIL misc ir=%h step %0d: got %h expected %h", irs[i], s, obs, exp_v);
                else n_pass++;
                if (s == 0) bus.IR = irs[i];
            end
        end
    endtask

    task automatic test_clear_mid();
        push_instr(32'h18A2_0000, 1'b0);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            exp_v = sb_q.pop_front();
            n_checks++;
            if (obs !== exp_v) $display("FAIL clear_pre step %0d: got %h expected %h", s, obs, exp_v);
            else n_pass++;
            if (s == 0) bus.IR = 32'h18A2_0000;
        end
        sb_q.delete();
        clear = 1'b1;
        #1;
        n_checks++;
        if (obs !== 33'h0) $display("FAIL clear_async: got %h expected %h", obs, 33'h0);
        else n_pass++;
        @(posedge clk); #1 clear = 1'b0;
        for (int k = 0; k < RESET_STEPS; k++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== 33'h0) $display("FAIL clear_idle %0d: got %h expected %h", k, obs, 33'h0);
            else n_pass++;
        end
    endtask

    task automatic test_halt();
        push_instr(32'hD800_0000, 1'b0);
        repeat (4) sb_q.push_back(33'h0);
        for (int s = 0; sb_q.size() > 0; s++) begin
            @(negedge clk);
            exp_v = sb_q.pop_front();
            n_checks++;
            if (obs !== exp_v) $display("FAIL halt step %0d: got %h expected %h", s, obs, exp_v);
            else n_pass++;
            if (s == 0) bus.IR = 32'hD800_0000;
            if (s == 4) bus.IR = 32'h18A2_0000;
        end
        clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        for (int k = 0; k < RESET_STEPS; k++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== 33'h0) $display("FAIL halt_idle %0d: got %h expected %h", k, obs, 33'h0);
            else n_pass++;
        end
    endtask

    task automatic test_stop();
        push_instr(32'h18A2_0000, 1'b0);
        repeat (3) sb_q.push_back(33'h0);
        for (int s = 0; sb_q.size() > 0; s++) begin
            @(negedge clk);
            exp_v = sb_q.pop_front();
            n_checks++;
            if (obs !== exp_v) $display("FAIL stop step %0d: got %h expected %h", s, obs, exp_v);
            else n_pass++;
            if (s == 0) bus.IR = 32'h18A2_0000;
            if (s == 5) bus.stop = 1'b1;
            if (s == 6) bus.stop = 1'b0;
        end
        clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        for (int k = 0; k < RESET_STEPS; k++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== 33'h0) $display("FAIL stop_idle %0d: got %h expected %h", k, obs, 33'h0);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] irs [2] = '{32'h18A2_0000, 32'h0080_0065};
        for (int i = 0; i < 2; i++) begin
            push_instr(irs[i], 1'b0);
            for (int s = 0; sb_q.size() > 0; s++) begin
                @(negedge clk);
                exp_v = sb_q.pop_front();
                n_checks++;
                if (obs !== exp_v) $display("FAIL b2b ir=%h step %0d: got %h expected %h", irs[i], s, obs, exp_v);
                else n_pass++;
                if (s == 0) bus.IR = irs[i];
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_br();
        test_mul();
        test_misc();
        test_clear_mid();
        test_back_to_back();
        test_halt();
        test_stop();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_unit.md
# control_unit

Moore-style sequencer for the single-bus CPU datapath. Holds a step state machine that runs fetch (T0–T2) and per-instruction execute steps (T3–T7), decoding the opcode in IR[31:27]. It drives every datapath control strobe, the ALU opcode, RAM read/write, the CON FF load, and the run/halt status. It replaces the testbench-driven control signals.

## Interface
Parameters:
- RESET_PC_STEPS, 1, number of idle cycles in the RESET state after `clear` deasserts, before the first T0.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- IR  in  32  instruction register contents; opcode = IR[31:27].
- CON  in  1  registered branch condition from the CON FF.
- stop  in  1  requests halt at the next instruction boundary.
- run  out  1  high while executing; low in RESET and HALT.
- Gra, Grb, Grc, Rin, Rout, BAout, Cout  out  1 each  select/encode controls.
- PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout  out  1 each  PC/IR/memory register controls.
- Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout  out  1 each  ALU/HI/LO controls.
- InPortout, Out_portIn, CONin  out  1 each  I/O and CON FF load.
- read, RAMwrite  out  1 each  RAM read (also MDR mux select: 1 = memory), RAM write.
- alu_op  out  5  ALU opcode.

## Operation
- States: RESET, T0–T7, HALT. All outputs decode from the registered state and IR only, with no input-to-output combinational path except through IR.
- Reset: state=RESET, run=0, and every control output is 0. After RESET_PC_STEPS cycles the FSM enters T0 with run=1.
- Fetch:
  - T0: PCout, MARin, IncPC.
  - T1: read, MDRin.
  - T2: MDRout, IRin.
- Execute (steps listed after T2; the last listed step returns to T0):
  - R-type (add, sub, and, or, ror, rol, shr, shra, shl):
    - T3: Grb Rout Yin.
    - T4: Grc Rout Zin.
    - T5: Zlowout Gra Rin.
  - neg, not: same as R-type, except T4 uses Grb Rout Zin.
  - addi, andi, ori:
    - T3: Grb Rout Yin.
    - T4: Cout Zin.
    - T5: Zlowout Gra Rin.
  - ldi: T3: Grb BAout Yin. T4: Cout Zin. T5: Zlowout Gra Rin.
  - ld: same T3–T4 as ldi, then:
    - T5: Zlowout MARin.
    - T6: read MDRin.
    - T7: MDRout Gra Rin.
  - st: same T3–T5 as ld, then:
    - T6: Gra Rout MDRin (read=0).
    - T7: RAMwrite.
  - br:
    - T3: Gra Rout CONin.
    - T4: PCout Yin.
    - T5: Cout Zin.
    - T6: if CON=1, Zlowout PCin; otherwise no strobes.
  - jr: T3: Gra Rout PCin.
  - jal: T3: PCout Grb Rin (link). T4: Gra Rout PCin.
  - mfhi: T3: HIout Gra Rin. mflo: T3: LOout Gra Rin.
  - in: T3: InPortout Gra Rin. out: T3: Gra Rout Out_portIn.
  - mul, div:
    - T3: Gra Rout Yin.
    - T4: Grb Rout Zin.
    - T5: Zlowout LOin.
    - T6: Zhighout HIin.
  - nop, and any unlisted opcode: T2→T0.
  - halt: T2→HALT.
- alu_op:
  - Equals IR[31:27] for ALU instructions.
  - Is add (00011) for ld, ldi, st, addi, br.
  - Is and (00101) for andi and or (00110) for ori.
  - Is 0 in all other states.
- stop: sampled on the final step of each instruction. If high, the FSM goes to HALT instead of T0.
- HALT: run=0, all strobes 0. It is left only via `clear`.
- `clear` mid-instruction aborts immediately to RESET with all outputs 0. Partial writes are not completed.

## Timing
- Every strobe is high for exactly one cycle. The datapath captures on the rising edge that ends that state.
- Instruction latency in cycles, fetch included:
  - nop: 3.
  - jr, mfhi, mflo, in, out: 4.
  - jal: 5.
  - R-type, immediate, ldi: 6.
  - br, mul/div: 7.
  - ld, st: 8.
- RAM read data is valid in the cycle `read` is asserted (T1 and ld T6).
- run falls on the clock edge that enters HALT, and falls asynchronously on `clear`.

## Configuration
- CU_MULDIV_EN:
  - Defined: mul (10000) and div (01111) sequence T3–T6 as above.
  - Undefined: both opcodes decode as nop (3 cycles, no HIin/LOin, no Zin).

## Structure
- Package cpu_pkg holds:
  - the 5-bit opcode localparams: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, addi 01100, andi 01101, ori 01110, div 01111, mul 10000, neg 10001, not 10010, br 10011, jr 10100, jal 10101, in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011;
  - the state enum.
- One sub-module, op_class_decode: combinational opcode → instruction class plus alu_op.

## Test plan
- Reset: assert `clear` mid-T4 of an add → all outputs 0 and run=0 immediately. After release, the first T0 asserts PCout, MARin, IncPC on cycle RESET_PC_STEPS+1.
- add (IR=0x18A20000): strobes follow T0–T5 exactly. Gra Rin appears in cycle 6, then T0 repeats.
- ld (IR=0x00800065):
  - alu_op=00011 in T4.
  - read=1 with MDRin in T1 and T6.
  - MDRout Gra Rin in T7.
  - 8 cycles total.
- br with CON=1, then again with CON=0: PCin asserted in T6 only when CON=1. Both take 7 cycles.
- mul (IR=0x81100000):
  - With CU_MULDIV_EN defined: LOin in T5, HIin in T6.
  - Undefined: T2→T0, no HIin or LOin.
- halt opcode: run falls after T2. Then stop=1 during an add's T5 → HALT and no next T0. Only `clear` recovers.
